// File: rtl/spi_register_map_pkg.sv
// Shared widths, register addresses and status constants for the SPI register map tile.
package spi_register_map_pkg;

    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int NUM_CFG  = 12;
    localparam int NUM_STAT = 4;
    localparam int AUDIO_DW = 8;
    localparam int LFSR_W   = 7;

    localparam int REG_OUT       = 0;
    localparam int REG_PRBS_EN   = 1;
    localparam int REG_PRBS_CTRL = 2;
    localparam int REG_AUDIO_SRC = 3;
    localparam int REG_LEFT      = 4;
    localparam int REG_RIGHT     = 5;

    // Status block sits directly above the config block; 12 and 13 read as zero.
    localparam logic [ADDR_W-1:0] CFG_LIMIT      = ADDR_W'(NUM_CFG);
    localparam logic [ADDR_W-1:0] ADDR_STAT_UI   = ADDR_W'(NUM_CFG + NUM_STAT - 2);
    localparam logic [ADDR_W-1:0] ADDR_STAT_ONES = ADDR_W'(NUM_CFG + NUM_STAT - 1);

    localparam logic [DATA_W-1:0] STAT_ZERO   = 8'h00;
    localparam logic [DATA_W-1:0] STAT_ONES   = 8'hFF;
    localparam logic [7:0]        UIO_OE_MASK = 8'b1100_0100;
    localparam logic [LFSR_W-1:0] LFSR_RESET  = 7'h01;

    // Fibonacci step for x^7 + x^6 + 1 (maximal length, period 127).
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[6] ^ s[5]};
    endfunction

endpackage

// File: rtl/spi_register_map_spi_slave.sv
// SPI mode-0 slave: synchronizes the pins to clk, decodes {rw, addr, data} frames
// and shifts read data out MSB first on falling sck edges.
module spi_slave
    import spi_register_map_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_sdi,
    input  logic              spi_cs_n,
    input  logic [DATA_W-1:0] rd_data,
    output logic              spi_sdo,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en
);

    localparam logic [4:0] FRAME_BITS = 5'd16;

    logic [1:0]        sck_sync;
    logic [1:0]        sdi_sync;
    logic [1:0]        cs_sync;
    logic              sck_prev;
    logic              sck_rise;
    logic              sck_fall;
    logic              cs_idle;
    logic [4:0]        bit_cnt;
    logic [6:0]        rx_shift;
    logic              rw_q;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_active;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync <= '0;
            sdi_sync <= '0;
            cs_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], spi_sck};
            sdi_sync <= {sdi_sync[0], spi_sdi};
            cs_sync  <= {cs_sync[0], spi_cs_n};
            sck_prev <= sck_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign cs_idle  = cs_sync[1];

    // rx_shift only needs 7 bits: the address is captured on bit 8, the data on bit 16.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            rw_q      <= 1'b0;
            addr      <= '0;
            wr_data   <= '0;
            wr_en     <= 1'b0;
            tx_shift  <= '0;
            tx_active <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (cs_idle) begin
                bit_cnt   <= '0;
                tx_shift  <= '0;
                tx_active <= 1'b0;
            end else begin
                if (sck_rise && bit_cnt != FRAME_BITS) begin
                    rx_shift <= {rx_shift[5:0], sdi_sync[1]};
                    bit_cnt  <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) begin
                        rw_q <= rx_shift[6];
                        addr <= {rx_shift[5:0], sdi_sync[1]};
                    end
                    if (bit_cnt == 5'd15) begin
                        wr_data <= {rx_shift, sdi_sync[1]};
                        wr_en   <= ~rw_q;
                    end
                end
                if (sck_fall) begin
                    if (bit_cnt == 5'd8 && rw_q) begin
                        tx_shift  <= rd_data;
                        tx_active <= 1'b1;
                    end else begin
                        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi_sdo = tx_shift[DATA_W-1] & tx_active & ~cs_idle;

endmodule

// File: rtl/spi_register_map.sv
// Tile top: SPI-accessible config/status registers driving uo_out, a PRBS-7 generator
// and an 8-bit I2S transmitter. Note rst_n is active-high despite its name.
module spi_register_map
    import spi_register_map_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [DATA_W-1:0]   cfg [NUM_CFG];
    logic [DATA_W-1:0]   rd_data;
    logic [ADDR_W-1:0]   spi_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                wr_en;
    logic                spi_sdo;
    logic [7:0]          ui_meta;
    logic [7:0]          ui_sync;
    logic [1:0]          i2s_sck_sync;
    logic [1:0]          i2s_ws_sync;
    logic                i2s_sck_prev;
    logic                i2s_ws_prev;
    logic                i2s_sck_fall;
    logic                i2s_ws_edge;
    logic [LFSR_W-1:0]   lfsr;
    logic [LFSR_W-1:0]   lfsr_seed;
    logic [AUDIO_DW-1:0] audio_sample;
    logic [AUDIO_DW-1:0] i2s_shift;
    logic [3:0]          i2s_bits;
    logic                i2s_sd;
    logic                prbs_out;
    logic                unused_inputs;

    spi_slave u_spi_slave (
        .clk      (clk),
        .rst      (rst_n),
        .spi_sck  (uio_in[0]),
        .spi_sdi  (uio_in[1]),
        .spi_cs_n (uio_in[3]),
        .rd_data  (rd_data),
        .spi_sdo  (spi_sdo),
        .addr     (spi_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_CFG; i++) cfg[i] <= '0;
        end else if (wr_en && spi_addr < CFG_LIMIT) begin
            cfg[spi_addr[3:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data = STAT_ZERO;
        if (spi_addr < CFG_LIMIT)             rd_data = cfg[spi_addr[3:0]];
        else if (spi_addr == ADDR_STAT_UI)    rd_data = ui_sync;
        else if (spi_addr == ADDR_STAT_ONES)  rd_data = STAT_ONES;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ui_meta      <= '0;
            ui_sync      <= '0;
            i2s_sck_sync <= '0;
            i2s_ws_sync  <= '0;
            i2s_sck_prev <= 1'b0;
            i2s_ws_prev  <= 1'b0;
        end else begin
            ui_meta      <= ui_in;
            ui_sync      <= ui_meta;
            i2s_sck_sync <= {i2s_sck_sync[0], uio_in[4]};
            i2s_ws_sync  <= {i2s_ws_sync[0], uio_in[5]};
            i2s_sck_prev <= i2s_sck_sync[1];
            i2s_ws_prev  <= i2s_ws_sync[1];
        end
    end

    assign i2s_sck_fall = ~i2s_sck_sync[1] & i2s_sck_prev;
    assign i2s_ws_edge  = i2s_ws_sync[1] ^ i2s_ws_prev;

    // While stopped the LFSR tracks the seed so a run always starts from it; zero would lock up.
    assign lfsr_seed = cfg[REG_PRBS_CTRL][LFSR_W-1:0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)                          lfsr <= LFSR_RESET;
        else if (cfg[REG_PRBS_CTRL][7])     lfsr <= lfsr_next(lfsr);
        else if (lfsr_seed == '0)           lfsr <= LFSR_RESET;
        else                                lfsr <= lfsr_seed;
    end

    assign prbs_out = lfsr[LFSR_W-1] & cfg[REG_PRBS_EN][0];

    always_comb begin
        audio_sample = {lfsr, 1'b0};
        if (cfg[REG_AUDIO_SRC][0]) audio_sample = i2s_ws_sync[1] ? cfg[REG_RIGHT] : cfg[REG_LEFT];
    end

    // A ws edge usually coincides with the fall that emits the previous word's last bit,
    // so sd is updated from the old shift register before the reload takes effect.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            i2s_shift <= '0;
            i2s_bits  <= '0;
            i2s_sd    <= 1'b0;
        end else begin
            if (i2s_sck_fall) i2s_sd <= (i2s_bits != 4'd0) ? i2s_shift[AUDIO_DW-1] : 1'b0;
            if (i2s_ws_edge) begin
                i2s_shift <= audio_sample;
                i2s_bits  <= 4'(AUDIO_DW);
            end else if (i2s_sck_fall && i2s_bits != 4'd0) begin
                i2s_shift <= {i2s_shift[AUDIO_DW-2:0], 1'b0};
                i2s_bits  <= i2s_bits - 4'd1;
            end
        end
    end

    assign uo_out        = cfg[REG_OUT];
    assign uio_out       = {prbs_out, i2s_sd, 3'b000, spi_sdo, 2'b00};
    assign uio_oe        = UIO_OE_MASK;
    assign unused_inputs = ^{ena, uio_in[7:6], uio_in[2]};

endmodule

// File: tb/tb_spi_register_map.sv
// Directed bench for spi_register_map: SPI register access, status map, PRBS-7 and I2S output,
// with read results and I2S words checked against a scoreboard queue.
module tb_spi_register_map;

    localparam int SPI_HALF = 500;
    localparam int I2S_HALF = 7800;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uio_in;
    logic       spi_sck = 1'b0;
    logic       spi_sdi = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       i2s_sck = 1'b0;
    logic       i2s_ws = 1'b0;

    int         assert_count = 0;
    int         fail_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_regs [12];
    logic       prbs_logging = 1'b0;
    logic       prbs_log[$];

    assign uio_in = {2'b00, i2s_ws, i2s_sck, spi_cs_n, 1'b0, spi_sdi, spi_sck};

    spi_register_map dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #50 clk = ~clk;

    always @(negedge clk) if (prbs_logging) prbs_log.push_back(uio_out[7]);

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog expired before end of test");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expectedRead(input logic [6:0] a);
        if (a < 7'd12)  return model_regs[a[3:0]];
        if (a == 7'd14) return ui_in;
        if (a == 7'd15) return 8'hFF;
        return 8'h00;
    endfunction

    task automatic spiFrame(input logic [15:0] frame, input int nbits, output logic [7:0] miso);
        miso = 8'h00;
        spi_cs_n = 1'b0;
        #(SPI_HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = frame[15-i];
            #(SPI_HALF);
            if (i >= 8) miso = {miso[6:0], uio_out[2]};
            spi_sck = 1'b1;
            #(SPI_HALF);
            spi_sck = 1'b0;
        end
        #(SPI_HALF);
        spi_cs_n = 1'b1;
        #(2*SPI_HALF);
    endtask

    task automatic applyStimulus(input logic rw, input logic [6:0] addr, input logic [7:0] data, input string tag);
        logic [7:0] miso;
        if (rw) exp_q.push_back(expectedRead(addr));
        spiFrame({rw, addr, data}, 16, miso);
        if (rw) begin
            checkOutput(tag, miso, exp_q.pop_front());
        end else begin
            checkOutput({tag, "_sdo"}, miso, 8'h00);
            if (addr < 7'd12) model_regs[addr[3:0]] = data;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] batch [8];
        logic [7:0] miso;
        logic [7:0] i2s_rx;
        logic [6:0] state;
        int         zero_at;
        int         f0;
        bit         prbs_ok;

        for (int i = 0; i < 12; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_uo_out", uo_out, 8'h00);
        checkOutput("rst_uio_out", uio_out, 8'h00);
        checkOutput("uio_oe", uio_oe, 8'hC4);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);

        applyStimulus(1'b1, 7'd0, 8'h00, "rd_reg0_reset");
        applyStimulus(1'b0, 7'd0, 8'hFF, "wr_reg0");
        applyStimulus(1'b1, 7'd0, 8'h00, "rd_reg0");
        checkOutput("uo_out_ff", uo_out, 8'hFF);

        for (int a = 1; a < 12; a += 2) begin
            d = 8'($urandom_range(0, 255));
            applyStimulus(1'b0, 7'(a), d, "wr_odd");
            applyStimulus(1'b1, 7'(a), 8'h00, "rd_odd");
        end
        for (int i = 0; i < 8; i++) begin
            batch[i] = 8'($urandom_range(0, 255));
            applyStimulus(1'b0, 7'(4 + i), batch[i], "wr_batch");
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 7'(4 + i), 8'h00, "rd_batch");

        ui_in = 8'hFF;
        #(10*100);
        applyStimulus(1'b1, 7'd13, 8'h00, "rd_stat13");
        applyStimulus(1'b1, 7'd15, 8'h00, "rd_stat15");
        applyStimulus(1'b1, 7'd14, 8'h00, "rd_stat14_ui");
        applyStimulus(1'b1, 7'h40, 8'h00, "rd_0x40");
        applyStimulus(1'b0, 7'd13, 8'h5A, "wr_stat13");
        applyStimulus(1'b1, 7'd13, 8'h00, "rd_stat13_after_wr");
        checkOutput("sdo_idle", 8'(uio_out[2]), 8'h00);

        spiFrame({1'b0, 7'd6, ~model_regs[6]}, 10, miso);
        applyStimulus(1'b1, 7'd6, 8'h00, "rd_after_abort");

        spi_cs_n = 1'b0;
        #(SPI_HALF);
        for (int i = 0; i < 5; i++) begin
            spi_sdi = 1'b1;
            #(SPI_HALF);
            spi_sck = 1'b1;
            #(SPI_HALF);
            spi_sck = 1'b0;
        end
        rst_n = 1'b1;
        #500;
        rst_n = 1'b0;
        spi_cs_n = 1'b1;
        #(2*SPI_HALF);
        for (int i = 0; i < 12; i++) model_regs[i] = 8'h00;
        checkOutput("uo_out_after_rst", uo_out, 8'h00);
        applyStimulus(1'b0, 7'd7, 8'h66, "wr_after_rst");
        applyStimulus(1'b1, 7'd7, 8'h00, "rd_after_rst");

        applyStimulus(1'b0, 7'd3, 8'h00, "wr_src_prbs");
        applyStimulus(1'b0, 7'd1, 8'hFF, "wr_prbs_en");
        applyStimulus(1'b0, 7'd2, 8'h7F, "wr_seed");
        #(10*100);
        prbs_logging = 1'b1;
        applyStimulus(1'b0, 7'd2, 8'hFF, "wr_run");
        #(400*100);
        prbs_logging = 1'b0;
        zero_at = -1;
        for (int i = 0; i < prbs_log.size(); i++) begin
            if (!prbs_log[i]) begin
                zero_at = i;
                break;
            end
        end
        prbs_ok = (zero_at >= 0) && (zero_at + 254 <= prbs_log.size());
        checkOutput("prbs_start", 8'(prbs_ok), 8'h01);
        if (prbs_ok) begin
            state = 7'h7F;
            repeat (7) state = {state[5:0], state[6] ^ state[5]};
            f0 = fail_count;
            for (int j = 0; j < 254; j++) begin
                checkOutput("prbs_bit", 8'(prbs_log[zero_at + j]), 8'(state[6]));
                if (fail_count != f0) break;
                state = {state[5:0], state[6] ^ state[5]};
            end
        end

        applyStimulus(1'b0, 7'd3, 8'h01, "wr_src_regs");
        applyStimulus(1'b0, 7'd4, 8'hA5, "wr_left");
        applyStimulus(1'b0, 7'd5, 8'h3C, "wr_right");
        i2s_sck = 1'b1;
        i2s_ws = 1'b1;
        #(4*I2S_HALF);
        i2s_rx = 8'h00;
        for (int k = 0; k <= 256; k++) begin
            i2s_sck = 1'b0;
            if (k % 8 == 0) begin
                i2s_ws = ((k / 8) % 2) != 0;
                if (k < 256) exp_q.push_back(i2s_ws ? 8'h3C : 8'hA5);
            end
            #(I2S_HALF);
            i2s_rx = {i2s_rx[6:0], uio_out[6]};
            if (k % 8 == 0 && k >= 8) checkOutput("i2s_sample", i2s_rx, exp_q.pop_front());
            i2s_sck = 1'b1;
            #(I2S_HALF);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
